// File: rtl/wallclock_pkg.sv
// Shared definitions for the wall-clock time-set controller: edit-field encodings,
// per-digit maxima and the single-field advance rule.
package wallclock_pkg;

  localparam logic [3:0] SEL_NONE   = 4'd0;
  localparam logic [3:0] SEL_SEC    = 4'd1;
  localparam logic [3:0] SEL_SEC10  = 4'd2;
  localparam logic [3:0] SEL_MIN    = 4'd3;
  localparam logic [3:0] SEL_MIN10  = 4'd4;
  localparam logic [3:0] SEL_HOUR   = 4'd5;
  localparam logic [3:0] SEL_HOUR10 = 4'd6;

  localparam logic [3:0] MAX_SEC        = 4'd9;
  localparam logic [3:0] MAX_SEC10      = 4'd5;
  localparam logic [3:0] MAX_MIN        = 4'd9;
  localparam logic [3:0] MAX_MIN10      = 4'd5;
  localparam logic [3:0] MAX_HOUR       = 4'd9;
  localparam logic [3:0] MAX_HOUR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_HOUR10     = 4'd2;

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Increments only the selected digit; digits never carry into each other.
  function automatic logic [23:0] advance_field(input logic [23:0] t, input logic [3:0] sel);
    logic [23:0] r;
    logic [3:0]  hour_max;
    r        = t;
    hour_max = (t[23:20] == MAX_HOUR10) ? MAX_HOUR_AT_20 : MAX_HOUR;
    case (sel)
      SEL_SEC:   r[3:0]   = wrap_inc(t[3:0], MAX_SEC);
      SEL_SEC10: r[7:4]   = wrap_inc(t[7:4], MAX_SEC10);
      SEL_MIN:   r[11:8]  = wrap_inc(t[11:8], MAX_MIN);
      SEL_MIN10: r[15:12] = wrap_inc(t[15:12], MAX_MIN10);
      SEL_HOUR:  r[19:16] = wrap_inc(t[19:16], hour_max);
      SEL_HOUR10: begin
        r[23:20] = wrap_inc(t[23:20], MAX_HOUR10);
        if (r[23:20] == MAX_HOUR10 && t[19:16] > MAX_HOUR_AT_20) begin
          r[19:16] = MAX_HOUR_AT_20;
        end
      end
      default: r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Conditions one raw active-low pushbutton: 2-FF synchronizer, level debouncer and a
// one-cycle pulse on each debounced press (1->0).
module key_debouncer #(
  parameter int unsigned DEBOUNCE_MAX = 999_999
) (
  input  logic clk,
  input  logic n_reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_MAX > 0) ? $clog2(DEBOUNCE_MAX + 1) : 1;

  logic            sync1_q, sync2_q, stable_q, press_q;
  logic [CntW-1:0] cnt_q;
  logic            settled;

  assign settled = (cnt_q == CntW'(DEBOUNCE_MAX));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // cnt_q counts consecutive samples that disagree with the accepted level.
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (settled) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Time-set controller: select steps through the six BCD fields, advance bumps the
// selected digit, and leaving the last field strobes the edited time into the clock.
module time_set_controller
  import wallclock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MAX = 999_999,
  parameter int unsigned BLINK_MAX    = 12_499_999
) (
  input  logic        CLOCK_50,
  input  logic        n_reset,
  input  logic        key_select_n,
  input  logic        key_advance_n,
  input  logic [23:0] time_in,
  output logic [3:0]  selected,
  output logic [23:0] time_out,
  output logic        load,
  output logic [5:0]  blank
);

  localparam int unsigned BlinkW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;

  logic              sel_ev, adv_ev;
  logic [3:0]        state_q, state_d;
  logic [23:0]       edit_q, edit_d;
  logic              load_q, load_d;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;

  key_debouncer #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key_select (
    .clk     (CLOCK_50),
    .n_reset (n_reset),
    .key_n   (key_select_n),
    .press   (sel_ev)
  );

  key_debouncer #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key_advance (
    .clk     (CLOCK_50),
    .n_reset (n_reset),
    .key_n   (key_advance_n),
    .press   (adv_ev)
  );

  // Select has priority; a coincident advance is dropped.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    load_d  = 1'b0;
    case (state_q)
      SEL_NONE: begin
        if (sel_ev) begin
          state_d = SEL_SEC;
          edit_d  = time_in;
        end
      end
      SEL_SEC, SEL_SEC10, SEL_MIN, SEL_MIN10, SEL_HOUR: begin
        if (sel_ev) begin
          state_d = state_q + 4'd1;
        end else if (adv_ev) begin
          edit_d = advance_field(edit_q, state_q);
        end
      end
      SEL_HOUR10: begin
        if (sel_ev) begin
          state_d = SEL_NONE;
          load_d  = 1'b1;
        end else if (adv_ev) begin
          edit_d = advance_field(edit_q, state_q);
        end
      end
      default: state_d = SEL_NONE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!n_reset) begin
      state_q <= SEL_NONE;
      edit_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      load_q  <= load_d;
    end
  end

  // Every field change restarts the blink with the digit visible.
  always_ff @(posedge CLOCK_50) begin
    if (!n_reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (state_d != state_q || state_q == SEL_NONE) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_MAX)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  always_comb begin
    blank = '0;
    case (state_q)
      SEL_SEC:    blank[0] = phase_q;
      SEL_SEC10:  blank[1] = phase_q;
      SEL_MIN:    blank[2] = phase_q;
      SEL_MIN10:  blank[3] = phase_q;
      SEL_HOUR:   blank[4] = phase_q;
      SEL_HOUR10: blank[5] = phase_q;
      default:    blank    = '0;
    endcase
  end

  assign selected = state_q;
  assign time_out = edit_q;
  assign load     = load_q;

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter DEBOUNCE_MAX, default 999_999, SHALL be the stable-cycle count minus 1 a key must hold before a level change is accepted (20 ms at 50 MHz).
REQ-002 Parameter BLINK_MAX, default 12_499_999, SHALL be the blink half-period in cycles minus 1 (4 Hz toggle).
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 n_reset  in  1  reset; synchronous, active-low.
REQ-005 key_select_n  in  1  raw select pushbutton; asynchronous; 0 = pressed.
REQ-006 key_advance_n  in  1  raw advance pushbutton; asynchronous; 0 = pressed.
REQ-007 time_in  in  24  live BCD time from the running clock: [3:0] seconds, [7:4] deca-seconds, [11:8] minutes, [15:12] deca-minutes, [19:16] hours, [23:20] deca-hours.
REQ-008 selected  out  4  current edit field: 0 NONE_SELECTED, 1 SECONDS, 2 SECONDSx10, 3 MINUTES, 4 MINUTESx10, 5 HOURS, 6 HOURSx10.
REQ-009 time_out  out  24  edit-register BCD digits, same packing as time_in.
REQ-010 load  out  1  one-cycle strobe; the running clock SHALL take time_out when load is high.
REQ-011 blank  out  6  per-digit blanking mask; bit k blanks display digit k.

Function
REQ-012 Each key SHALL pass through a 2-FF synchronizer, then a debouncer that updates its stable level only after DEBOUNCE_MAX+1 consecutive identical synchronized samples.
REQ-013 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release SHALL produce no event.
REQ-014 FSM SHALL hold one of the seven states in REQ-008, reset state NONE_SELECTED, and change state only on select events.
REQ-015 Select event in NONE_SELECTED SHALL copy time_in into the edit register and enter SECONDS on the next cycle.
REQ-016 Select events SHALL step SECONDS->SECONDSx10->MINUTES->MINUTESx10->HOURS->HOURSx10.
REQ-017 Select event in HOURSx10 SHALL enter NONE_SELECTED and assert load for exactly the next cycle with time_out holding the edited value.
REQ-018 Illegal state encodings (7-15) SHALL return to NONE_SELECTED on the next cycle, without asserting load.
REQ-019 An advance event SHALL increment the selected digit by 1 on the next cycle, with wrap: seconds 9->0, deca-seconds 5->0, minutes 9->0, deca-minutes 5->0, deca-hours 2->0.
REQ-020 The hours digit SHALL wrap 9->0 when deca-hours < 2, and 3->0 when deca-hours = 2.
REQ-021 When deca-hours advances to 2 while hours > 3, hours SHALL be set to 3 in the same cycle.
REQ-022 An advance event in NONE_SELECTED SHALL be ignored; carries SHALL never propagate between digits.
REQ-023 If select and advance events occur in the same cycle, select SHALL take effect and advance SHALL be discarded.
REQ-024 The blink counter SHALL run only while selected != NONE, SHALL toggle the blink phase at BLINK_MAX and then wrap to 0, and SHALL clear to 0 (phase 0) on every state change.
REQ-025 blank[selected-1] SHALL equal the blink phase; all other blank bits SHALL be 0; in NONE_SELECTED blank SHALL be 0.
REQ-026 In NONE_SELECTED, time_out SHALL equal the value last copied (edit register unchanged).

Reset
REQ-027 With n_reset=0 at a clock edge, the controller SHALL set selected=0, time_out=0, load=0, blank=0, the blink counter and phase to 0, and the debounced levels to 1 (released); the debouncer counters SHALL be cleared.
REQ-028 Reset during an edit SHALL abandon it with no load pulse.

Structure
REQ-029 The state encodings and the per-digit maxima (9,5,9,5,9/3,2) SHALL live in the shared package wallclock_pkg.
REQ-030 Synchronizer, debouncer and edge detector SHALL form one sub-module, key_debouncer, instantiated twice.

Verification (DEBOUNCE_MAX=3, BLINK_MAX=7)
REQ-031 Press and release select with time_in=0x123456 -> selected=1 and time_out=0x123456; a 2-cycle glitch on the key -> no change.
REQ-032 In SECONDS with digit 6, 5 advance presses -> seconds digit reads 7,8,9,0,1.
REQ-033 Edit 0x195959: set HOURSx10 and advance once -> deca-hours 2, hours clamped to 3, time_out=0x235959; one more advance -> deca-hours 0.
REQ-034 Walk all 6 fields then press select -> load high exactly 1 cycle, selected=0, time_out equal to the edited value.
REQ-035 In MINUTES with the keys idle -> blank=6'b000100 for 8 cycles, then 0 for 8 cycles, repeating; selected=0 -> blank=0.
REQ-036 Reset asserted mid-edit in HOURS -> next cycle selected=0, time_out=0, no load; select and advance debounced in the same cycle -> state advances, digit unchanged.
